// File: rtl/snd_pkg.sv
// Shared defaults and types for the sound PWM output stage.
package snd_pkg;
  localparam int DW_DEF       = 16;
  localparam int PWM_BITS_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

  // Offset that maps signed 0 to the middle of the unsigned range.
  localparam logic [DW_DEF-1:0] MID_SCALE = {1'b1, {(DW_DEF-1){1'b0}}};
endpackage

// File: rtl/snd_pwm_quant.sv
// Combinational quantiser: signed sample plus carried residue -> PWM duty and new residue.
module snd_pwm_quant
  import snd_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic [DW-1:0]          i_hold,
  input  logic [DW-PWM_BITS-1:0] i_err,
  output logic [PWM_BITS-1:0]    o_duty,
  output logic [DW-PWM_BITS-1:0] o_err
);
  localparam int EW = DW - PWM_BITS;
  // Same value as MID_SCALE, sized to this instance's DW.
  localparam logic [DW-1:0] OFS = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] w_u;
  logic [DW:0]   w_acc;

  assign w_u   = i_hold + OFS;
  assign w_acc = {1'b0, w_u} + {{(PWM_BITS+1){1'b0}}, i_err};

  // A carry out of the top bit pins the output at full scale with maximal residue.
  always_comb begin
    o_duty = w_acc[DW-1:EW];
    o_err  = w_acc[EW-1:0];
    if (w_acc[DW]) begin
      o_duty = '1;
      o_err  = '1;
    end
  end
endmodule

// File: rtl/snd_pwm_dac.sv
// Sound PWM DAC: sample capture, period FSM, noise-shaped duty load, PWM output, overrun flag.
module snd_pwm_dac
  import snd_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic          CLK_IN,
  input  logic          RST,
  input  logic          enable,
  input  logic [DW-1:0] snd,
  input  logic          snd_sample,
  input  logic          ovr_clr,
  output logic          snd_pwm,
  output logic          ovr
);
  localparam int EW = DW - PWM_BITS;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  pwm_state_t          r_state;
  logic [DW-1:0]       r_hold;
  logic                r_fresh;
  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic [EW-1:0]       r_err;

  logic [PWM_BITS-1:0] w_duty;
  logic [EW-1:0]       w_err;
  logic                w_load;

  snd_pwm_quant #(.DW(DW), .PWM_BITS(PWM_BITS)) u_quant (
    .i_hold (r_hold),
    .i_err  (r_err),
    .o_duty (w_duty),
    .o_err  (w_err)
  );

  // Load on the enabling edge, then once per period at the counter wrap.
  assign w_load = enable && ((r_state == IDLE) || (r_cnt == CNT_MAX));

  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_fresh <= 1'b0;
      r_cnt   <= '0;
      r_duty  <= '0;
      r_err   <= '0;
      snd_pwm <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (snd_sample) r_hold <= snd;

      if (snd_sample)  r_fresh <= 1'b1;
      else if (w_load) r_fresh <= 1'b0;

      // A strobe that lands on a load replaces a sample just consumed, so it is not an overrun.
      if (snd_sample && r_fresh && !w_load) ovr <= 1'b1;
      else if (ovr_clr)                     ovr <= 1'b0;

      snd_pwm <= (r_state == RUN) && (r_cnt < r_duty);

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_duty  <= w_duty;
            r_err   <= w_err;
          end
        end
        RUN: begin
          if (!enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_duty  <= '0;
            r_err   <= '0;
          end else if (w_load) begin
            r_cnt  <= '0;
            r_duty <= w_duty;
            r_err  <= w_err;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snd_pwm_dac.sv
// Directed bench for snd_pwm_dac: a 10-bit PWM instance plus a 4-bit one for the reset case.
module tb_snd_pwm_dac;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, smp, clr, pwm, ovr;
  logic [15:0] snd;
  logic        rst4_n, en4, smp4, clr4, pwm4, ovr4;
  logic [15:0] snd4;

  int n_run  = 0;
  int n_fail = 0;

  snd_pwm_dac #(.DW(16), .PWM_BITS(10)) u_dut (
    .CLK_IN(clk), .RST(rst_n), .enable(en), .snd(snd), .snd_sample(smp),
    .ovr_clr(clr), .snd_pwm(pwm), .ovr(ovr)
  );

  snd_pwm_dac #(.DW(16), .PWM_BITS(4)) u_dut4 (
    .CLK_IN(clk), .RST(rst4_n), .enable(en4), .snd(snd4), .snd_sample(smp4),
    .ovr_clr(clr4), .snd_pwm(pwm4), .ovr(ovr4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_hi(input bit four, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      hi += four ? int'(pwm4) : int'(pwm);
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    snd = v;
    smp = 1'b1;
    @(negedge clk);
    smp = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h;
    int t;
    rst_n = 0; en = 0; smp = 0; clr = 0; snd = '0;
    rst4_n = 0; en4 = 0; smp4 = 0; clr4 = 0; snd4 = '0;
    cycles(3);
    chk("rst_pwm", pwm, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_pwm4", pwm4, 0);
    rst_n = 1; rst4_n = 1;
    cycles(2);

    // Mid-scale: duty 512, high starting one clock after the load.
    @(negedge clk) en = 1;
    @(negedge clk);
    chk("load_edge_pwm", pwm, 0);
    chk("mid_duty", u_dut.r_duty, 512);
    @(negedge clk);
    chk("first_hi", pwm, 1);
    cycles(511);
    chk("last_hi", pwm, 1);
    cycles(1);
    chk("first_lo", pwm, 0);
    count_hi(0, 1024, h);
    chk("mid_window", h, 512);

    // Disable, capture while idle, re-enable loads immediately: duty 0/1 alternating.
    @(negedge clk) en = 0;
    cycles(2);
    chk("dis_pwm", pwm, 0);
    chk("dis_cnt", u_dut.r_cnt, 0);
    strobe(16'h8020);
    chk("idle_ovr", ovr, 0);
    @(negedge clk) en = 1;
    @(negedge clk);
    chk("reload_duty", u_dut.r_duty, 0);
    chk("reload_err", u_dut.r_err, 32);
    count_hi(0, 2048, h);
    chk("alt_window", h, 1);

    // Drop enable mid-period while err is nonzero.
    cycles(300);
    @(negedge clk) en = 0;
    cycles(2);
    chk("drop_pwm", pwm, 0);
    chk("drop_cnt", u_dut.r_cnt, 0);
    chk("drop_err", u_dut.r_err, 0);
    chk("drop_duty", u_dut.r_duty, 0);
    count_hi(0, 50, h);
    chk("idle_window", h, 0);

    // Two strobes inside one period -> overrun; the second value wins.
    @(negedge clk) en = 1;
    cycles(100);
    strobe(16'h8000);
    chk("ovr_first", ovr, 0);
    cycles(100);
    strobe(16'h7FFF);
    chk("ovr_set", ovr, 1);
    @(negedge clk) clr = 1;
    @(negedge clk);
    chk("ovr_clr", ovr, 0);
    clr = 0;
    cycles(900);
    count_hi(0, 1024, h);
    chk("sat_window", h, 1023);

    // Strobe exactly on the load cycle does not flag overrun.
    strobe(16'h8000);
    t = 0;
    while (u_dut.r_cnt != 10'h3FF && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_wrap", (t < 2000), 1);
    snd = 16'h8000;
    smp = 1'b1;
    @(negedge clk) smp = 1'b0;
    chk("ovr_on_load", ovr, 0);

    // Overrun set and clear in the same cycle: set wins.
    cycles(10);
    snd = 16'h8000; smp = 1'b1; clr = 1'b1;
    @(negedge clk);
    smp = 1'b0; clr = 1'b0;
    chk("set_wins", ovr, 1);
    clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    chk("ovr_clr2", ovr, 0);
    cycles(1100);
    count_hi(0, 1024, h);
    chk("neg_window", h, 0);

    // 4-bit instance: full-scale sample with overrun, then async reset mid-period.
    @(negedge clk) en4 = 1;
    @(negedge clk) begin snd4 = 16'h7FFF; smp4 = 1'b1; end
    @(negedge clk);
    @(negedge clk) smp4 = 1'b0;
    chk("d4_ovr", ovr4, 1);
    cycles(18);
    chk("d4_hi", pwm4, 1);
    #2 rst4_n = 0;
    #1;
    chk("d4_rst_pwm", pwm4, 0);
    chk("d4_rst_ovr", ovr4, 0);
    @(negedge clk) rst4_n = 1;
    @(negedge clk);
    chk("d4_duty", u_dut4.r_duty, 8);
    count_hi(1, 16, h);
    chk("d4_window", h, 8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/snd_pwm_dac.md
# snd_pwm_dac

Sound output stage downstream of the sound selector/mixer. Captures signed PCM sound samples on a one-cycle sample strobe, holds the latest sample, and converts it to a single-bit PWM stream on `snd_pwm` for the board's RC low-pass filter. Quantisation residue is fed back period to period, which adds first-order noise shaping. The stage has a double-buffered sample path and a sticky overrun flag.

## Interface
- `DW`, 16: sample width, signed two's complement.
- `PWM_BITS`, 10: PWM resolution. Period is 2^PWM_BITS clocks. Must satisfy 2 ≤ PWM_BITS < DW.

- `CLK_IN`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run PWM; low forces idle.
- `snd`  in  DW  signed sample; valid when `snd_sample`=1.
- `snd_sample`  in  1  one-cycle sample strobe.
- `ovr_clr`  in  1  clears `ovr`.
- `snd_pwm`  out  1  PWM output, registered.
- `ovr`  out  1  sticky overrun: two samples arrived within one period.

## Operation
- **Registers:** `hold` (DW), `fresh` (1), `cnt` (PWM_BITS), `duty` (PWM_BITS), `err` (DW-PWM_BITS), `state` ∈ {IDLE, RUN}, `snd_pwm`, `ovr`. Reset clears all of them to 0 and sets state to IDLE. `hold`=0 means mid-scale.
- **Capture:** on `snd_sample`=1, `hold` <= `snd` and `fresh` <= 1. Capture happens in both states.
- **Load:** a load event occurs on the IDLE→RUN edge, or in RUN when `cnt`=2^PWM_BITS-1. A load performs the following:
  - u = `hold` + 2^(DW-1), as unsigned DW bits.
  - acc = u + `err`, as DW+1 bits.
  - If acc[DW]=0: `duty` <= acc[DW-1:DW-PWM_BITS] and `err` <= acc[DW-PWM_BITS-1:0].
  - If acc[DW]=1 (saturation): `duty` <= 2^PWM_BITS-1 and `err` <= 2^(DW-PWM_BITS)-1.
  - `cnt` <= 0 and `fresh` <= 0.
- **Held sample:** with no new sample, each period re-quantises the same `hold`. The error feedback keeps running across these periods.
- **FSM:**
  - IDLE→RUN when `enable`=1. This edge performs the load.
  - RUN→IDLE at any cycle with `enable`=0. That edge sets `cnt`, `duty` and `err` to 0.
  - In RUN, `cnt` increments every cycle and wraps to 0 via the load.
- **Output:** `snd_pwm` <= (state==RUN) && (`cnt` < `duty`). So duty 0 is always low, and duty max is high for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
- **Overrun:** `ovr` is set when `snd_sample`=1 while `fresh`=1 and no load occurs in the same cycle. The new sample overwrites `hold`.
- **Sample coincident with load:** the load uses the old `hold`. After the edge, `fresh`=1 from the new sample, and no overrun is flagged.
- **`ovr_clr` coincident with an overrun set:** set wins.
- **Reset mid-period:** output goes low immediately (asynchronous). After release, the block is IDLE with a mid-scale `hold`.

## Timing
- The duty computed at a load edge appears on `snd_pwm` starting one clock later. Example: load at edge E0 sets `cnt`=0; `snd_pwm` is high from edge E1 when `duty`>0.
- A sample takes effect at the next load edge. Latency from strobe to output is 2 to 2^PWM_BITS+1 clocks.
- `enable` falling: `snd_pwm` goes low at the second edge after the deassertion is sampled. Any registered high bit drains first.
- `ovr` rises one clock after the offending strobe edge and falls one clock after `ovr_clr`.
- No combinational input→output paths.

## Structure
- Package `snd_pkg` contains:
  - DW and PWM_BITS defaults.
  - the `pwm_state_t` enum {IDLE, RUN}.
  - the mid-scale offset localparam.
- Sub-module `snd_pwm_quant` is combinational. It takes `hold` and `err` and returns `duty` and `err` with the saturation rule. The top level owns capture, FSM, counter, output and overrun logic.

## Test plan
(DW=16, PWM_BITS=10 unless noted.)
- Reset, then `enable`=1 with no sample: `duty`=512. Every period shows exactly 512 high cycles, starting one clock after each load.
- `snd`=-32768 strobed: after the next load, `snd_pwm` stays 0 for entire periods. With `snd`=32767: `duty`=1023 every period (saturated), giving 1023 high and 1 low cycle.
- `snd`=-32736 (u=32): successive periods produce duty 0, 1, 0, 1… (`err` 32, 0, 32, 0). That is 1 high cycle per 2048 clocks.
- Two strobes 100 cycles apart inside one period: `ovr`=1 and the second value is used at the next load. `ovr_clr` drops `ovr` one clock later. A strobe exactly on the load cycle: `ovr` stays 0.
- Drop `enable` mid-period: `snd_pwm` stays 0 and `cnt`/`err` are 0. A strobe while IDLE is captured; re-enable loads it immediately.
- PWM_BITS=4, assert `RST` low mid-period: `snd_pwm` and `ovr` are 0 asynchronously. After release, the first enabled period has duty 8 of 16.
